// File: rtl/torture_mem_responder_if.sv
// Native picorv32 memory bus, including the look-ahead signals.
// The CPU side drives requests through master; the responder answers through slave.
interface torture_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_la_read;
  logic        mem_la_write;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [3:0]  mem_la_wstrb;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/torture_mem_responder.sv
// Word memory responder for the picorv32 torture bench: xorshift32 wait states, CPU reset
// sequencing, sticky trap/timeout status and a backdoor port. Define TORTURE_MEM_LA_EN for look-ahead accepts.
module torture_mem_responder #(
  parameter int unsigned MEM_WORDS      = 4096,
  parameter logic [31:0] SEED           = 32'd314159265,
  parameter logic [31:0] STALL_MASK     = 32'h1,
  parameter int unsigned RESET_CYCLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  localparam int unsigned AW            = $clog2(MEM_WORDS)
) (
  input  logic                         clk,
  input  logic                         resetn,
  output logic                         cpu_resetn,
  input  logic                         trap,
  torture_mem_responder_if.slave       bus,
  input  logic                         dbg_we,
  input  logic [AW-1:0]                dbg_addr,
  input  logic [31:0]                  dbg_wdata,
  output logic [31:0]                  dbg_rdata,
  output logic                         halted,
  output logic                         timeout,
  output logic [15:0]                  rd_count,
  output logic [15:0]                  wr_count
);

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] x32_q, x32_d;
  logic        cpu_resetn_q, cpu_resetn_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        halted_q, halted_d;
  logic        timeout_q, timeout_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic          go;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wword;

  always_comb begin
    cycle_d      = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
    cpu_resetn_d = (cycle_q > RESET_CYCLES);
    x32_d        = cpu_resetn_q ? xorshift32(x32_q) : x32_q;
    halted_d     = halted_q | (trap & cpu_resetn_q);
    timeout_d    = timeout_q | ((cycle_q > TIMEOUT_CYCLES) & ~halted_q);
    go           = cpu_resetn_q & ~halted_q & ((x32_q & STALL_MASK) == STALL_MASK);
    mem_ready_d  = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    dbg_rdata_d  = mem_q[dbg_addr];
    mem_be       = 4'b0000;
    mem_widx     = '0;
    mem_wword    = '0;

    // Backdoor and CPU writes can never collide: the backdoor only works while the CPU is held in reset.
    if (!cpu_resetn_q && dbg_we) begin
      mem_be    = 4'b1111;
      mem_widx  = dbg_addr;
      mem_wword = dbg_wdata;
    end

    if (go) begin
`ifdef TORTURE_MEM_LA_EN
      if (bus.mem_la_read) begin
        mem_ready_d = 1'b1;
        mem_rdata_d = mem_q[bus.mem_la_addr[AW+1:2]];
        rd_count_d  = rd_count_q + 16'd1;
      end else if (bus.mem_la_write) begin
        mem_ready_d = 1'b1;
        mem_be      = bus.mem_la_wstrb;
        mem_widx    = bus.mem_la_addr[AW+1:2];
        mem_wword   = bus.mem_la_wdata;
        wr_count_d  = wr_count_q + 16'd1;
      end else
`endif
      if (bus.mem_valid && !mem_ready_q) begin
        mem_ready_d = 1'b1;
        if (bus.mem_wstrb != 4'b0000) begin
          mem_be     = bus.mem_wstrb;
          mem_widx   = bus.mem_addr[AW+1:2];
          mem_wword  = bus.mem_wdata;
          wr_count_d = wr_count_q + 16'd1;
        end else begin
          mem_rdata_d = mem_q[bus.mem_addr[AW+1:2]];
          rd_count_d  = rd_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_q      <= '0;
      x32_q        <= SEED;
      cpu_resetn_q <= 1'b0;
      mem_ready_q  <= 1'b0;
      mem_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
    end else begin
      cycle_q      <= cycle_d;
      x32_q        <= x32_d;
      cpu_resetn_q <= cpu_resetn_d;
      mem_ready_q  <= mem_ready_d;
      mem_rdata_q  <= mem_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Memory contents deliberately survive reset so a loaded program outlives a CPU restart.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) mem_q[mem_widx][8*b +: 8] <= mem_wword[8*b +: 8];
    end
  end

  logic unused_bits;
`ifdef TORTURE_MEM_LA_EN
  assign unused_bits = ^{bus.mem_instr, bus.mem_addr, bus.mem_la_addr};
`else
  assign unused_bits = ^{bus.mem_instr, bus.mem_addr, bus.mem_la_read, bus.mem_la_write,
                         bus.mem_la_addr, bus.mem_la_wdata, bus.mem_la_wstrb};
`endif

  assign cpu_resetn    = cpu_resetn_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign dbg_rdata     = dbg_rdata_q;
  assign halted        = halted_q;
  assign timeout       = timeout_q;
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_torture_mem_responder.sv
// Self-checking bench for torture_mem_responder: dut0 never stalls and times out early,
// dut1 uses the default xorshift stall pattern.
module tb_torture_mem_responder;
  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  int   tb_cyc;

  logic        cpu_resetn0, trap0, dbg_we0, halted0, timeout0;
  logic [5:0]  dbg_addr0;
  logic [31:0] dbg_wdata0, dbg_rdata0;
  logic [15:0] rd_count0, wr_count0;

  logic        cpu_resetn1, trap1, dbg_we1, halted1, timeout1;
  logic [5:0]  dbg_addr1;
  logic [31:0] dbg_wdata1, dbg_rdata1;
  logic [15:0] rd_count1, wr_count1;

  logic [31:0] exp_q[$];
  logic        exp_rdy_q[$];

  torture_mem_responder_if bus0();
  torture_mem_responder_if bus1();

  torture_mem_responder #(.MEM_WORDS(64), .STALL_MASK(32'h0), .TIMEOUT_CYCLES(50)) dut0 (
    .clk(clk), .resetn(resetn), .cpu_resetn(cpu_resetn0), .trap(trap0), .bus(bus0),
    .dbg_we(dbg_we0), .dbg_addr(dbg_addr0), .dbg_wdata(dbg_wdata0), .dbg_rdata(dbg_rdata0),
    .halted(halted0), .timeout(timeout0), .rd_count(rd_count0), .wr_count(wr_count0));

  torture_mem_responder #(.MEM_WORDS(64)) dut1 (
    .clk(clk), .resetn(resetn), .cpu_resetn(cpu_resetn1), .trap(trap1), .bus(bus1),
    .dbg_we(dbg_we1), .dbg_addr(dbg_addr1), .dbg_wdata(dbg_wdata1), .dbg_rdata(dbg_rdata1),
    .halted(halted1), .timeout(timeout1), .rd_count(rd_count1), .wr_count(wr_count1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) tb_cyc <= 0;
    else         tb_cyc <= tb_cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at tb_cyc=%0d", tb_cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] tb_xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic cpu_access0(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output int lat, output logic [31:0] rdata);
    @(negedge clk);
    bus0.mem_addr  = addr;
    bus0.mem_wdata = wdata;
    bus0.mem_wstrb = wstrb;
    bus0.mem_valid = 1'b1;
    lat   = -1;
    rdata = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus0.mem_ready === 1'b1) begin
        lat   = i;
        rdata = bus0.mem_rdata;
        break;
      end
    end
    bus0.mem_valid = 1'b0;
    bus0.mem_wstrb = 4'b0000;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_resetn0 !== 1'b0) begin failures++; $display("FAIL rst_cpu_resetn got=%b exp=0", cpu_resetn0); end
    checks++; if (bus0.mem_ready !== 1'b0) begin failures++; $display("FAIL rst_mem_ready got=%b exp=0", bus0.mem_ready); end
    checks++; if (bus0.mem_rdata !== 32'h0) begin failures++; $display("FAIL rst_mem_rdata got=%h exp=0", bus0.mem_rdata); end
    checks++; if (halted0 !== 1'b0 || timeout0 !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", halted0, timeout0); end
    checks++; if (rd_count0 !== 16'h0 || wr_count0 !== 16'h0) begin failures++; $display("FAIL rst_counts got=%h/%h exp=0/0", rd_count0, wr_count0); end
    dbg_we0 = 1'b1;
    dbg_addr0 = 6'd4; dbg_wdata0 = 32'hCAFEF00D; @(negedge clk);
    dbg_addr0 = 6'd2; dbg_wdata0 = 32'h11223344; @(negedge clk);
    dbg_addr0 = 6'd3; dbg_wdata0 = 32'h03030303; @(negedge clk);
    dbg_addr0 = 6'd5; dbg_wdata0 = 32'h55AA55AA; @(negedge clk);
    dbg_we0 = 1'b0;
    checks++; if (dbg_rdata0 !== 32'h0) begin failures++; $display("FAIL rst_dbg_rdata got=%h exp=0", dbg_rdata0); end
    resetn = 1'b1;
    repeat (11) @(negedge clk);
    checks++; if (cpu_resetn0 !== 1'b0) begin failures++; $display("FAIL cpu_resetn_early got=%b exp=0", cpu_resetn0); end
    @(negedge clk);
    checks++; if (cpu_resetn0 !== 1'b1) begin failures++; $display("FAIL cpu_resetn_release got=%b exp=1", cpu_resetn0); end
  endtask

  task automatic test_read();
    int lat;
    logic [31:0] rd, e;
    exp_q.push_back(32'hCAFEF00D);
    cpu_access0(32'h10, 32'h0, 4'b0000, lat, rd);
    checks++; if (lat !== 1) begin failures++; $display("FAIL read_latency got=%0d exp=1", lat); end
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL read_data got=%h exp=%h", rd, e); end
    @(negedge clk);
    checks++; if (bus0.mem_ready !== 1'b0) begin failures++; $display("FAIL ready_pulse got=%b exp=0", bus0.mem_ready); end
    checks++; if (rd_count0 !== 16'd1 || wr_count0 !== 16'd0) begin failures++; $display("FAIL read_counts got=%0d/%0d exp=1/0", rd_count0, wr_count0); end
  endtask

  task automatic test_write();
    int lat;
    logic [31:0] rd, e;
    cpu_access0(32'h08, 32'hAABBCCDD, 4'b0101, lat, rd);
    checks++; if (lat !== 1) begin failures++; $display("FAIL write_latency got=%0d exp=1", lat); end
    checks++; if (wr_count0 !== 16'd1) begin failures++; $display("FAIL write_count got=%0d exp=1", wr_count0); end
    exp_q.push_back(32'h11BB33DD);
    dbg_addr0 = 6'd2;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (dbg_rdata0 !== e) begin failures++; $display("FAIL byte_write got=%h exp=%h", dbg_rdata0, e); end
    // address 0x10B: word 66 wraps to word 2, low bits ignored
    exp_q.push_back(32'h11BB33DD);
    cpu_access0(32'h10B, 32'h0, 4'b0000, lat, rd);
    e = exp_q.pop_front();
    checks++; if (lat !== 1 || rd !== e) begin failures++; $display("FAIL wrap_read got=%h lat=%0d exp=%h lat=1", rd, lat, e); end
    dbg_we0 = 1'b1; dbg_addr0 = 6'd3; dbg_wdata0 = 32'hFFFFFFFF;
    @(negedge clk);
    dbg_we0 = 1'b0;
    @(negedge clk);
    checks++; if (dbg_rdata0 !== 32'h03030303) begin failures++; $display("FAIL backdoor_guard got=%h exp=03030303", dbg_rdata0); end
    cpu_access0(32'h18, 32'h600DF00D, 4'b1111, lat, rd);
    exp_q.push_back(32'h600DF00D);
    cpu_access0(32'h18, 32'h0, 4'b0000, lat, rd);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin failures++; $display("FAIL full_write_read got=%h exp=%h", rd, e); end
    checks++; if (rd_count0 !== 16'd3 || wr_count0 !== 16'd2) begin failures++; $display("FAIL rw_counts got=%0d/%0d exp=3/2", rd_count0, wr_count0); end
  endtask

  task automatic test_stall();
    logic [31:0] x;
    logic        rdy, crn, go, got, e;
    logic [15:0] nrd;
    bus1.mem_addr = 32'h0; bus1.mem_wstrb = 4'b0000; bus1.mem_valid = 1'b1;
    do_reset();
    x = 32'd314159265; rdy = 1'b0; nrd = '0;
    for (int k = 1; k <= 300; k++) begin
      crn = (k >= 13);
      go  = crn && ((x & 32'h1) == 32'h1);
      rdy = go && !rdy;
      if (crn) x = tb_xs(x);
      if (rdy) nrd++;
      exp_rdy_q.push_back(rdy);
      @(negedge clk);
      got = bus1.mem_ready;
      e   = exp_rdy_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", k, got, e); end
    end
    bus1.mem_valid = 1'b0;
    checks++; if (rd_count1 !== nrd) begin failures++; $display("FAIL stall_rd_count got=%0d exp=%0d", rd_count1, nrd); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (51) @(negedge clk);
    checks++; if (timeout0 !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", timeout0); end
    @(negedge clk);
    checks++; if (timeout0 !== 1'b1) begin failures++; $display("FAIL timeout_rise got=%b exp=1", timeout0); end
    checks++; if (halted0 !== 1'b0) begin failures++; $display("FAIL timeout_halted got=%b exp=0", halted0); end
    checks++; if (timeout1 !== 1'b0) begin failures++; $display("FAIL timeout_default got=%b exp=0", timeout1); end
  endtask

  task automatic test_halt();
    int n, nrdy;
    n = 0;
    while (tb_cyc != 200 && n < 400) begin @(negedge clk); n++; end
    checks++; if (halted0 !== 1'b0) begin failures++; $display("FAIL halt_before got=%b exp=0", halted0); end
    trap0 = 1'b1;
    @(negedge clk);
    trap0 = 1'b0;
    checks++; if (halted0 !== 1'b1) begin failures++; $display("FAIL halt_rise cyc=%0d got=%b exp=1", tb_cyc, halted0); end
    bus0.mem_addr = 32'h14; bus0.mem_wdata = 32'hDEADBEEF; bus0.mem_wstrb = 4'b1111; bus0.mem_valid = 1'b1;
    nrdy = 0;
    repeat (20) begin @(negedge clk); if (bus0.mem_ready === 1'b1) nrdy++; end
    bus0.mem_valid = 1'b0; bus0.mem_wstrb = 4'b0000;
    checks++; if (nrdy !== 0) begin failures++; $display("FAIL halt_no_ready got=%0d exp=0", nrdy); end
    checks++; if (wr_count0 !== 16'd0) begin failures++; $display("FAIL halt_wr_count got=%0d exp=0", wr_count0); end
    dbg_addr0 = 6'd5;
    @(negedge clk);
    checks++; if (dbg_rdata0 !== 32'h55AA55AA) begin failures++; $display("FAIL halt_mem got=%h exp=55aa55aa", dbg_rdata0); end
    checks++; if (halted0 !== 1'b1 || timeout0 !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%b%b exp=11", halted0, timeout0); end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    @(negedge clk);
    checks++; if (halted0 !== 1'b0) begin failures++; $display("FAIL halt_cleared got=%b exp=0", halted0); end
    n = 0;
    while (cpu_resetn0 !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    checks++; if (cpu_resetn0 !== 1'b1) begin failures++; $display("FAIL async_cpu_up got=%b exp=1", cpu_resetn0); end
    bus0.mem_addr = 32'h10; bus0.mem_wstrb = 4'b0000; bus0.mem_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus0.mem_ready !== 1'b1) begin failures++; $display("FAIL async_pre_ready got=%b exp=1", bus0.mem_ready); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus0.mem_ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%b exp=0", bus0.mem_ready); end
    checks++; if (cpu_resetn0 !== 1'b0) begin failures++; $display("FAIL async_cpu_resetn got=%b exp=0", cpu_resetn0); end
    bus0.mem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (13) @(negedge clk);
    checks++; if (rd_count0 !== 16'd0) begin failures++; $display("FAIL async_rd_count got=%0d exp=0", rd_count0); end
    dbg_addr0 = 6'd4; @(negedge clk);
    checks++; if (dbg_rdata0 !== 32'hCAFEF00D) begin failures++; $display("FAIL keep_mem4 got=%h exp=cafef00d", dbg_rdata0); end
    dbg_addr0 = 6'd2; @(negedge clk);
    checks++; if (dbg_rdata0 !== 32'h11BB33DD) begin failures++; $display("FAIL keep_mem2 got=%h exp=11bb33dd", dbg_rdata0); end
    dbg_addr0 = 6'd6; @(negedge clk);
    checks++; if (dbg_rdata0 !== 32'h600DF00D) begin failures++; $display("FAIL keep_mem6 got=%h exp=600df00d", dbg_rdata0); end
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0;
    trap0 = 1'b0; dbg_we0 = 1'b0; dbg_addr0 = '0; dbg_wdata0 = '0;
    trap1 = 1'b0; dbg_we1 = 1'b0; dbg_addr1 = '0; dbg_wdata1 = '0;
    bus0.mem_valid = 1'b0; bus0.mem_instr = 1'b0; bus0.mem_addr = '0; bus0.mem_wdata = '0; bus0.mem_wstrb = '0;
    bus0.mem_la_read = 1'b0; bus0.mem_la_write = 1'b0; bus0.mem_la_addr = '0; bus0.mem_la_wdata = '0; bus0.mem_la_wstrb = '0;
    bus1.mem_valid = 1'b0; bus1.mem_instr = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0; bus1.mem_wstrb = '0;
    bus1.mem_la_read = 1'b0; bus1.mem_la_write = 1'b0; bus1.mem_la_addr = '0; bus1.mem_la_wdata = '0; bus1.mem_la_wstrb = '0;
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_timeout();
    test_halt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
